// File: rtl/xc_malu_issue.sv
// Issue/retire stage in front of the multi-cycle arithmetic unit (xc_malu).
// Optional watchdog abort is compiled in with XC_MALU_ISSUE_TIMEOUT_EN.
module xc_malu_issue #(
    parameter int unsigned RD_W           = 5,
    parameter int unsigned CYC_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 127
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [4:0]       req_pw,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [31:0]      req_rs3,
    input  logic [RD_W-1:0]  req_rd,
    output logic [31:0]      malu_rs1,
    output logic [31:0]      malu_rs2,
    output logic [31:0]      malu_rs3,
    output logic [13:0]      malu_uop,
    output logic [4:0]       malu_pw,
    output logic             malu_valid,
    output logic             malu_flush,
    input  logic [63:0]      malu_result,
    input  logic             malu_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_result,
    output logic             rsp_wide,
    output logic [RD_W-1:0]  rsp_rd,
    output logic             rsp_illegal,
    output logic             rsp_error,
    output logic [CYC_W-1:0] rsp_cycles
);
    localparam int unsigned OP_W   = 4;
    localparam int unsigned UOP_W  = 14;
    localparam int unsigned PW_W   = 5;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned RES_W  = 64;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state, state_d;
    logic [CYC_W-1:0] cnt, cnt_d, cnt_inc;
    logic             abort, abort_d;
    logic             timeout_hit;

    logic [XLEN-1:0]  malu_rs1_d, malu_rs2_d, malu_rs3_d;
    logic [UOP_W-1:0] malu_uop_d;
    logic [PW_W-1:0]  malu_pw_d;
    logic             malu_valid_d;
    logic             rsp_valid_d, rsp_wide_d, rsp_illegal_d, rsp_error_d;
    logic [RES_W-1:0] rsp_result_d;
    logic [RD_W-1:0]  rsp_rd_d;
    logic [CYC_W-1:0] rsp_cycles_d;

    logic             op_legal;
    logic             op_wide;

    assign req_ready = (state == S_IDLE) && !flush;
    assign malu_flush = flush | abort;

    assign op_legal = (req_op <= OP_W'(13));
    assign op_wide  = (req_op >= OP_W'(10)) && (req_op <= OP_W'(13));

`ifndef XC_MALU_ISSUE_TIMEOUT_EN
    // The watchdog limit is only consulted when the watchdog is built in.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        abort_d       = 1'b0;
        malu_rs1_d    = malu_rs1;
        malu_rs2_d    = malu_rs2;
        malu_rs3_d    = malu_rs3;
        malu_uop_d    = malu_uop;
        malu_pw_d     = malu_pw;
        malu_valid_d  = malu_valid;
        rsp_valid_d   = rsp_valid;
        rsp_result_d  = rsp_result;
        rsp_wide_d    = rsp_wide;
        rsp_rd_d      = rsp_rd;
        rsp_illegal_d = rsp_illegal;
        rsp_error_d   = rsp_error;
        rsp_cycles_d  = rsp_cycles;

        cnt_inc     = (cnt == '1) ? cnt : cnt + CYC_W'(1);
        timeout_hit = 1'b0;
`ifdef XC_MALU_ISSUE_TIMEOUT_EN
        timeout_hit = (cnt_inc >= CYC_W'(TIMEOUT_CYCLES));
`endif

        if (flush) begin
            state_d       = S_IDLE;
            cnt_d         = '0;
            malu_rs1_d    = '0;
            malu_rs2_d    = '0;
            malu_rs3_d    = '0;
            malu_uop_d    = '0;
            malu_pw_d     = '0;
            malu_valid_d  = 1'b0;
            rsp_valid_d   = 1'b0;
            rsp_result_d  = '0;
            rsp_wide_d    = 1'b0;
            rsp_rd_d      = '0;
            rsp_illegal_d = 1'b0;
            rsp_error_d   = 1'b0;
            rsp_cycles_d  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        malu_pw_d     = req_pw;
                        rsp_rd_d      = req_rd;
                        rsp_wide_d    = op_wide;
                        rsp_error_d   = 1'b0;
                        rsp_illegal_d = !op_legal;
                        if (op_legal) begin
                            state_d      = S_BUSY;
                            cnt_d        = '0;
                            malu_valid_d = 1'b1;
                            malu_uop_d   = UOP_W'(1) << req_op;
                            malu_rs1_d   = req_rs1;
                            malu_rs2_d   = req_rs2;
                            malu_rs3_d   = req_rs3;
                        end else begin
                            // Illegal ops never reach the unit.
                            state_d      = S_DONE;
                            rsp_valid_d  = 1'b1;
                            rsp_result_d = '0;
                            rsp_cycles_d = '0;
                        end
                    end
                end
                S_BUSY: begin
                    cnt_d = cnt_inc;
                    if (malu_ready || timeout_hit) begin
                        state_d      = S_DONE;
                        rsp_valid_d  = 1'b1;
                        malu_valid_d = 1'b0;
                        malu_uop_d   = '0;
                        malu_rs1_d   = '0;
                        malu_rs2_d   = '0;
                        malu_rs3_d   = '0;
                        if (malu_ready) begin
                            rsp_result_d = malu_result;
                            rsp_cycles_d = cnt_inc;
                            rsp_error_d  = 1'b0;
                        end else begin
                            abort_d      = 1'b1;
                            rsp_result_d = '0;
                            rsp_cycles_d = CYC_W'(TIMEOUT_CYCLES);
                            rsp_error_d  = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        state_d     = S_IDLE;
                        rsp_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            abort       <= 1'b0;
            malu_rs1    <= '0;
            malu_rs2    <= '0;
            malu_rs3    <= '0;
            malu_uop    <= '0;
            malu_pw     <= '0;
            malu_valid  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_wide    <= 1'b0;
            rsp_rd      <= '0;
            rsp_illegal <= 1'b0;
            rsp_error   <= 1'b0;
            rsp_cycles  <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            abort       <= abort_d;
            malu_rs1    <= malu_rs1_d;
            malu_rs2    <= malu_rs2_d;
            malu_rs3    <= malu_rs3_d;
            malu_uop    <= malu_uop_d;
            malu_pw     <= malu_pw_d;
            malu_valid  <= malu_valid_d;
            rsp_valid   <= rsp_valid_d;
            rsp_result  <= rsp_result_d;
            rsp_wide    <= rsp_wide_d;
            rsp_rd      <= rsp_rd_d;
            rsp_illegal <= rsp_illegal_d;
            rsp_error   <= rsp_error_d;
            rsp_cycles  <= rsp_cycles_d;
        end
    end
endmodule

// File: doc/xc_malu_issue.md
Name: xc_malu_issue

Overview:
Issue/retire stage directly upstream of the multi-cycle arithmetic unit (xc_malu).
- Accepts one decoded request per transaction: 4-bit op code, pack width, three 32-bit operands and destination tag.
- Converts the op code to the unit's one-hot uop lines and holds them, the operands and valid stable for the whole operation.
- Captures the 64-bit result when the unit signals ready and presents it downstream with a valid/ready handshake, together with a measured latency.

Parameters:
- RD_W, 5, destination register tag width.
- CYC_W, 8, width of the latency counter.
- TIMEOUT_CYCLES, 127, watchdog limit (used only with the optional feature).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; abandons any transaction.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when high with req_valid.
- req_op  in  4  0 div, 1 divu, 2 rem, 3 remu, 4 mul, 5 mulu, 6 mulsu, 7 clmul, 8 pmul, 9 pclmul, 10 madd, 11 msub, 12 macc, 13 mmul; 14–15 illegal.
- req_pw  in  5  {pw_2, pw_4, pw_8, pw_16, pw_32}.
- req_rs1, req_rs2, req_rs3  in  32 each  operands.
- req_rd  in  RD_W  destination tag.
- malu_rs1, malu_rs2, malu_rs3  out  32 each  held operands.
- malu_uop  out  14  one-hot; bit n corresponds to op code n.
- malu_pw  out  5  held pack width.
- malu_valid  out  1  operation valid.
- malu_flush  out  1  flush to the unit.
- malu_result  in  64  unit result.
- malu_ready  in  1  unit result ready (combinational from the unit).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  downstream accepts the response.
- rsp_result  out  64  captured result.
- rsp_wide  out  1  set for ops 10–13 (register-pair writeback).
- rsp_rd  out  RD_W  destination tag.
- rsp_illegal  out  1  op code was 14 or 15.
- rsp_error  out  1  watchdog abort (optional feature only; otherwise tied to 0).
- rsp_cycles  out  CYC_W  cycles spent in BUSY.

Behaviour:
- State machine has three states: IDLE, BUSY, DONE.
- Reset: state IDLE; all registered outputs, latched operands, uop, pw, result and counter are 0. req_ready is 1 after reset (IDLE, flush low).
- req_ready = (state == IDLE) && !flush. No accept in BUSY or DONE.
- IDLE, on accept:
  - Latch operands, pw, rd and op.
  - Legal op: go to BUSY and clear the counter.
  - Illegal op: go directly to DONE with rsp_illegal=1, rsp_result=0 and rsp_cycles=0. malu_valid is never raised.
- BUSY:
  - malu_valid=1; malu_uop, malu_pw and malu_rs* are stable.
  - Counter increments each cycle and saturates at all-ones.
  - When malu_ready=1: capture malu_result, set rsp_cycles = counter+1 (saturating) and go to DONE.
- DONE:
  - rsp_valid=1 and malu_valid=0. Deasserting valid here is mandatory so the unit does not restart.
  - On rsp_ready=1, go to IDLE and drop rsp_valid in the next cycle.
  - Response fields stay stable while rsp_valid=1 and rsp_ready=0.
- malu_uop and malu_rs* are zero outside BUSY.
- malu_flush = flush, OR watchdog abort when the optional feature is compiled in.
- Latency:
  - Accept in cycle N → malu_valid high from N+1.
  - malu_ready in cycle M → rsp_valid high from M+1.
  - Minimum request-to-response time is 2 cycles plus the unit's latency.
- Flush:
  - Any state returns to IDLE in the next cycle; rsp_valid drops and latched state is cleared.
  - Flush beats a simultaneous request (req_ready is 0) and a simultaneous malu_ready (result discarded).
- Reset mid-operation behaves like flush and additionally zeroes everything.
- rsp_wide = latched op in 10..13.

Optional Feature:
XC_MALU_ISSUE_TIMEOUT_EN
- With the macro: if the counter reaches TIMEOUT_CYCLES in BUSY without malu_ready, then:
  - malu_flush pulses for exactly one cycle;
  - the block moves to DONE with rsp_error=1, rsp_result=0 and rsp_cycles=TIMEOUT_CYCLES.
  - If malu_ready arrives in the same cycle as the limit, the result wins and rsp_error=0.
- Without the macro: no watchdog; rsp_error is constant 0; malu_flush = flush.

Test Plan:
- Reset, then mulu with rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → rsp_result=0xFFFFFFFE00000001, rsp_wide=0, rsp_rd echoed, malu_valid low in the DONE cycle.
- divu with rs1=100, rs2=7 → rsp_result[31:0]=14. The unit model is fixed at 10-cycle latency → rsp_cycles=10, and rsp_valid rises exactly 1 cycle after malu_ready.
- req_op=15 → rsp_valid 1 cycle after accept, rsp_illegal=1, rsp_result=0, malu_valid never high.
- Hold rsp_ready=0 for 5 cycles in DONE → req_ready=0 and rsp_* stable throughout. Release → IDLE, next request accepted the cycle after.
- flush in BUSY concurrent with malu_ready → no response, state IDLE, malu_flush=1 that cycle. Same-cycle req_valid with flush → not accepted.
- Timeout (macro on, TIMEOUT_CYCLES=4, unit model never ready) → single-cycle malu_flush, rsp_error=1, rsp_cycles=4. With macro off → block stays in BUSY indefinitely.
